axi4lite_host_port: RTL and testbench
=====================================

# axi4lite_host_port

Single-outstanding AXI4-Lite initiator that turns the core's load/store requests into AXI4-Lite read or write transactions on the host bus. The dmemory and UART responders sit on that bus. It sits between the core's memory-access stage and the host bus, and is the initiator end of the interface those responders implement. It issues one transaction at a time, handles AW/W handshakes in either order, and returns a single-cycle completion pulse with read data and an error flag.

## Interface
- AXI_AWIDTH, 32, AXI address width
- AXI_DWIDTH, 32, AXI data width; must be 32 (WSTRB width = AXI_DWIDTH/8 = 4)
- CLK  in  1  sole clock; all logic rising-edge
- RST  in  1  asynchronous, active-high reset
- REQ_VALID  in  1  core request valid
- REQ_READY  out  1  port can accept a request
- REQ_WE  in  1  1 = write, 0 = read
- REQ_ADDR  in  AXI_AWIDTH  byte address, passed through unmodified
- REQ_WDATA  in  AXI_DWIDTH  write data, lane-aligned by core
- REQ_WSTRB  in  AXI_DWIDTH/8  byte enables, ignored for reads
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_RDATA  out  AXI_DWIDTH  read data; 0 after writes
- RSP_ERR  out  1  1 if RESP was SLVERR or DECERR
- HOST_AXI_AW{ADDR,VALID,READY}, HOST_AXI_W{DATA,STRB,VALID,READY}, HOST_AXI_B{RESP,VALID,READY}, HOST_AXI_AR{ADDR,VALID,READY}, HOST_AXI_R{DATA,RESP,VALID,READY}: standard AXI4-Lite initiator directions and widths (RESP 2 bits)

## Operation
- FSM states: IDLE, WRITE, READ_ADDR, READ_DATA.
- IDLE
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY, register addr/wdata/wstrb.
  - Go to WRITE if REQ_WE=1, else READ_ADDR.
- WRITE
  - AWVALID and WVALID are asserted together and held with stable payload.
  - Each channel has a done flag. A channel's VALID drops the cycle after its own handshake, independent of the other channel.
  - BREADY=1 once both done flags are set.
  - On BVALID&BREADY: capture BRESP, go to IDLE.
- READ_ADDR
  - ARVALID=1 until ARREADY. Then go to READ_DATA.
- READ_DATA
  - RREADY=1. On RVALID&RREADY: capture RDATA/RRESP, go to IDLE.
- Completion
  - RSP_VALID=1 for exactly one cycle, the cycle after the B or R handshake.
  - RSP_ERR = (resp[1]==1). OKAY and EXOKAY count as success.
  - RSP_RDATA is valid only while RSP_VALID=1 and holds until the next completion.
- Early responses
  - A BVALID arriving before both AW and W are done is not accepted (BREADY low).
  - An RVALID arriving while in READ_ADDR is not accepted.
- Requests arriving outside IDLE are not accepted; the core holds them.
- Never more than one outstanding transaction.
- No timeout. A non-responding target stalls the port indefinitely.

## Timing
- Reset values: REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, all AXI VALID/READY=0, AXI payload outputs=0, FSM=IDLE, done flags=0.
- Reset mid-transaction: all VALID/READY drop immediately (asynchronous). The transaction is abandoned and no RSP_VALID is issued. Responders share the reset.
- Write, zero-wait responder:
  - cycle 0: accept
  - cycle 1: AW+W handshake
  - cycle 2: BREADY=1, B handshake
  - cycle 3: RSP_VALID
  - Total: 3 cycles accept to completion.
- Read, zero-wait responder:
  - cycle 0: accept
  - cycle 1: AR handshake
  - cycle 2: R handshake
  - cycle 3: RSP_VALID
- REQ_READY returns high in the RSP_VALID cycle, so back-to-back issue is possible: the next accept coincides with the previous completion.
- AXI outputs are registered; no combinational path from any *READY/*VALID input to any output.

## Structure
- Shared package holds:
  - the state enum (IDLE, WRITE, READ_ADDR, READ_DATA)
  - AXI response constants: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
- Single module; no sub-module warranted.

## Test plan
- Write 0x0000_0010 / 0xDEAD_BEEF / strb 4'hF, zero-wait responder, BRESP=OKAY:
  - AW+W accepted in the same cycle
  - RSP_VALID 3 cycles after accept, RSP_ERR=0, RSP_RDATA=0
- Write with AWREADY at cycle 1 and WREADY at cycle 4:
  - AWVALID drops after cycle 1; WVALID held through cycle 4
  - BREADY low until cycle 5
  - Early BVALID at cycle 3 is not accepted
- Read 0x0000_0004, RVALID after 5 wait cycles, RDATA=0x1234_5678, RRESP=OKAY:
  - ARVALID held until ARREADY
  - RSP_VALID pulse carries 0x1234_5678
- Read with RRESP=DECERR, then write with BRESP=SLVERR:
  - both return RSP_ERR=1
  - read RSP_RDATA equals the captured RDATA
- Back-to-back write, read, write with REQ_VALID held high:
  - each new accept coincides with the prior RSP_VALID
  - never two transactions in flight
- Assert RST while WVALID is pending:
  - all AXI outputs 0 asynchronously, no RSP_VALID
  - after release, a new read completes normally

Source files
------------

// File: rtl/axi4lite_host_port_pkg.sv
// axi4lite_host_port_pkg: FSM state type, AXI response codes and error decode shared by the host port
package axi4lite_host_port_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ_ADDR, READ_DATA} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  function automatic logic is_err(input logic [1:0] resp);
    return resp == RESP_SLVERR || resp == RESP_DECERR;
  endfunction
endpackage

// File: rtl/axi4lite_host_port.sv
// axi4lite_host_port: single-outstanding AXI4-Lite initiator; core REQ_* in, one-cycle RSP_* pulse out, HOST_AXI_* initiator channels
module axi4lite_host_port
  import axi4lite_host_port_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_WE,
  input  logic [AXI_AWIDTH-1:0]   REQ_ADDR,
  input  logic [AXI_DWIDTH-1:0]   REQ_WDATA,
  input  logic [AXI_DWIDTH/8-1:0] REQ_WSTRB,
  output logic                    RSP_VALID,
  output logic [AXI_DWIDTH-1:0]   RSP_RDATA,
  output logic                    RSP_ERR,
  output logic [AXI_AWIDTH-1:0]   HOST_AXI_AWADDR,
  output logic                    HOST_AXI_AWVALID,
  input  logic                    HOST_AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0]   HOST_AXI_WDATA,
  output logic [AXI_DWIDTH/8-1:0] HOST_AXI_WSTRB,
  output logic                    HOST_AXI_WVALID,
  input  logic                    HOST_AXI_WREADY,
  input  logic [1:0]              HOST_AXI_BRESP,
  input  logic                    HOST_AXI_BVALID,
  output logic                    HOST_AXI_BREADY,
  output logic [AXI_AWIDTH-1:0]   HOST_AXI_ARADDR,
  output logic                    HOST_AXI_ARVALID,
  input  logic                    HOST_AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0]   HOST_AXI_RDATA,
  input  logic [1:0]              HOST_AXI_RRESP,
  input  logic                    HOST_AXI_RVALID,
  output logic                    HOST_AXI_RREADY
);
  state_t state, state_n;
  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_done, w_done;
  logic [AXI_AWIDTH-1:0] addr;
  assign REQ_READY = state == IDLE;
  assign accept = REQ_VALID && REQ_READY;
  assign aw_hs = HOST_AXI_AWVALID && HOST_AXI_AWREADY;
  assign w_hs = HOST_AXI_WVALID && HOST_AXI_WREADY;
  assign b_hs = HOST_AXI_BVALID && HOST_AXI_BREADY;
  assign ar_hs = HOST_AXI_ARVALID && HOST_AXI_ARREADY;
  assign r_hs = HOST_AXI_RVALID && HOST_AXI_RREADY;
  assign HOST_AXI_AWADDR = addr;
  assign HOST_AXI_ARADDR = addr;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = accept ? (REQ_WE ? WRITE : READ_ADDR) : IDLE;
      WRITE:     state_n = b_hs ? IDLE : WRITE;
      READ_ADDR: state_n = ar_hs ? READ_DATA : READ_ADDR;
      READ_DATA: state_n = r_hs ? IDLE : READ_DATA;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_n;
  // Each write channel drops its VALID right after its own handshake; BREADY
  // waits until both channels are done so an early B response is never taken.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      addr <= '0;
      HOST_AXI_WDATA <= '0;
      HOST_AXI_WSTRB <= '0;
      HOST_AXI_AWVALID <= 1'b0;
      HOST_AXI_WVALID <= 1'b0;
      HOST_AXI_BREADY <= 1'b0;
      HOST_AXI_ARVALID <= 1'b0;
      HOST_AXI_RREADY <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR <= 1'b0;
    end else begin
      if (accept) addr <= REQ_ADDR;
      if (accept && REQ_WE) HOST_AXI_WDATA <= REQ_WDATA;
      if (accept && REQ_WE) HOST_AXI_WSTRB <= REQ_WSTRB;
      HOST_AXI_AWVALID <= (accept && REQ_WE) || (HOST_AXI_AWVALID && !aw_hs);
      HOST_AXI_WVALID <= (accept && REQ_WE) || (HOST_AXI_WVALID && !w_hs);
      aw_done <= state == WRITE && !b_hs && (aw_done || aw_hs);
      w_done <= state == WRITE && !b_hs && (w_done || w_hs);
      HOST_AXI_BREADY <= state == WRITE && !b_hs && (aw_done || aw_hs) && (w_done || w_hs);
      HOST_AXI_ARVALID <= (accept && !REQ_WE) || (HOST_AXI_ARVALID && !ar_hs);
      HOST_AXI_RREADY <= (state == READ_ADDR && ar_hs) || (HOST_AXI_RREADY && !r_hs);
      RSP_VALID <= b_hs || r_hs;
      if (b_hs || r_hs) RSP_RDATA <= r_hs ? HOST_AXI_RDATA : '0;
      if (b_hs || r_hs) RSP_ERR <= is_err(r_hs ? HOST_AXI_RRESP : HOST_AXI_BRESP);
    end
endmodule

// File: tb/tb_axi4lite_host_port.sv
// tb_axi4lite_host_port: directed self-checking bench for axi4lite_host_port
module tb_axi4lite_host_port;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0;
  logic req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_wstrb = '0;
  logic rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0] wstrb;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;
  int total = 0, bad = 0;

  axi4lite_host_port dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .REQ_WSTRB(req_wstrb),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata), .RSP_ERR(rsp_err),
    .HOST_AXI_AWADDR(awaddr), .HOST_AXI_AWVALID(awvalid), .HOST_AXI_AWREADY(awready),
    .HOST_AXI_WDATA(wdata), .HOST_AXI_WSTRB(wstrb), .HOST_AXI_WVALID(wvalid), .HOST_AXI_WREADY(wready),
    .HOST_AXI_BRESP(bresp), .HOST_AXI_BVALID(bvalid), .HOST_AXI_BREADY(bready),
    .HOST_AXI_ARADDR(araddr), .HOST_AXI_ARVALID(arvalid), .HOST_AXI_ARREADY(arready),
    .HOST_AXI_RDATA(rdata), .HOST_AXI_RRESP(rresp), .HOST_AXI_RVALID(rvalid), .HOST_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_wstrb = s;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk32("rst_axi_ctl", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'h0);
    chk32("rst_awaddr", awaddr, 32'h0);
    chk32("rst_wdata", wdata, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // zero-wait write, OKAY
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    chk1("w0_awvalid", awvalid, 1'b1);
    chk1("w0_wvalid", wvalid, 1'b1);
    chk32("w0_awaddr", awaddr, 32'h0000_0010);
    chk32("w0_wdata", wdata, 32'hDEAD_BEEF);
    chk32("w0_wstrb", 32'(wstrb), 32'hF);
    chk1("w0_req_ready_busy", req_ready, 1'b0);
    chk1("w0_bready_c1", bready, 1'b0);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk32("w0_valids_c2", 32'({awvalid, wvalid}), 32'h0);
    chk1("w0_bready_c2", bready, 1'b1);
    chk1("w0_rsp_c2", rsp_valid, 1'b0);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk1("w0_rsp_c3", rsp_valid, 1'b1);
    chk1("w0_err", rsp_err, 1'b0);
    chk32("w0_rdata", rsp_rdata, 32'h0);
    chk1("w0_req_ready_c3", req_ready, 1'b1);
    chk1("w0_bready_c3", bready, 1'b0);
    tick();
    chk1("w0_rsp_pulse", rsp_valid, 1'b0);

    // write with AWREADY at cycle 1, WREADY at cycle 4, early BVALID at cycle 3
    issue(1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'h3);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk1("w1_awvalid_c2", awvalid, 1'b0);
    chk1("w1_wvalid_c2", wvalid, 1'b1);
    chk1("w1_bready_c2", bready, 1'b0);
    chk32("w1_wstrb", 32'(wstrb), 32'h3);
    tick();
    bvalid = 1'b1; bresp = 2'b10;
    chk1("w1_bready_c3", bready, 1'b0);
    chk1("w1_wvalid_c3", wvalid, 1'b1);
    tick();
    bresp = 2'b00;
    chk1("w1_early_b_rsp", rsp_valid, 1'b0);
    chk1("w1_bready_c4", bready, 1'b0);
    chk1("w1_wvalid_c4", wvalid, 1'b1);
    chk32("w1_wdata_held", wdata, 32'hCAFE_0001);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    chk1("w1_wvalid_c5", wvalid, 1'b0);
    chk1("w1_bready_c5", bready, 1'b1);
    tick();
    bvalid = 1'b0;
    chk1("w1_rsp", rsp_valid, 1'b1);
    chk1("w1_err", rsp_err, 1'b0);
    tick();
    chk1("w1_rsp_pulse", rsp_valid, 1'b0);

    // read with ARREADY delayed, early RVALID ignored, RVALID after 5 waits
    issue(1'b0, 32'h0000_0004, 32'h0, 4'h0);
    chk1("r0_arvalid_c1", arvalid, 1'b1);
    chk32("r0_araddr", araddr, 32'h0000_0004);
    chk1("r0_awvalid", awvalid, 1'b0);
    rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
    tick();
    rvalid = 1'b0;
    chk1("r0_early_r_rready", rready, 1'b0);
    chk1("r0_arvalid_c2", arvalid, 1'b1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk1("r0_arvalid_c3", arvalid, 1'b0);
    chk1("r0_rready_c3", rready, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk1("r0_rsp_wait", rsp_valid, 1'b0);
    chk1("r0_rready_wait", rready, 1'b1);
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    chk1("r0_rsp", rsp_valid, 1'b1);
    chk32("r0_rdata", rsp_rdata, 32'h1234_5678);
    chk1("r0_err", rsp_err, 1'b0);
    tick();
    chk1("r0_rsp_pulse", rsp_valid, 1'b0);
    chk32("r0_rdata_hold", rsp_rdata, 32'h1234_5678);

    // read DECERR then write SLVERR
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hA5A5_0F0F; rresp = 2'b11;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    chk1("r1_rsp", rsp_valid, 1'b1);
    chk1("r1_err", rsp_err, 1'b1);
    chk32("r1_rdata", rsp_rdata, 32'hA5A5_0F0F);
    tick();
    issue(1'b1, 32'h0000_0200, 32'h5555_AAAA, 4'hC);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = 2'b10;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    chk1("w2_rsp", rsp_valid, 1'b1);
    chk1("w2_err", rsp_err, 1'b1);
    chk32("w2_rdata", rsp_rdata, 32'h0);
    tick();

    // back-to-back write, read, write with REQ_VALID held high
    req_we = 1'b1; req_addr = 32'h0000_0300; req_wdata = 32'h0101_0101; req_wstrb = 4'hF;
    req_valid = 1'b1;
    tick();
    req_we = 1'b0; req_addr = 32'h0000_0304;
    chk1("bb_w_req_ready", req_ready, 1'b0);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    chk1("bb_w_arvalid", arvalid, 1'b0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk1("bb_w_rsp", rsp_valid, 1'b1);
    chk1("bb_w_req_ready", req_ready, 1'b1);
    tick();
    req_we = 1'b1; req_addr = 32'h0000_0308; req_wdata = 32'h0202_0202;
    chk1("bb_r_arvalid", arvalid, 1'b1);
    chk32("bb_r_araddr", araddr, 32'h0000_0304);
    chk1("bb_r_awvalid", awvalid, 1'b0);
    chk1("bb_r_rsp_low", rsp_valid, 1'b0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h1122_3344;
    tick();
    rvalid = 1'b0;
    chk1("bb_r_rsp", rsp_valid, 1'b1);
    chk32("bb_r_rdata", rsp_rdata, 32'h1122_3344);
    chk1("bb_r_req_ready", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk1("bb_w2_awvalid", awvalid, 1'b1);
    chk1("bb_w2_arvalid", arvalid, 1'b0);
    chk32("bb_w2_wdata", wdata, 32'h0202_0202);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk1("bb_w2_rsp", rsp_valid, 1'b1);
    chk32("bb_w2_rdata", rsp_rdata, 32'h0);
    tick();
    chk1("bb_idle", req_ready, 1'b1);

    // reset while WVALID pending
    issue(1'b1, 32'h0000_0400, 32'h7777_8888, 4'hF);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    chk1("rm_wvalid_pending", wvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk32("rm_axi_ctl", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'h0);
    chk32("rm_wdata", wdata, 32'h0);
    chk32("rm_awaddr", awaddr, 32'h0);
    chk1("rm_req_ready", req_ready, 1'b1);
    bvalid = 1'b1;
    tick();
    chk1("rm_no_rsp", rsp_valid, 1'b0);
    bvalid = 1'b0;
    rst = 1'b0;
    tick();
    chk1("rm_no_rsp2", rsp_valid, 1'b0);
    issue(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    chk1("rm_r_arvalid", arvalid, 1'b1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BAD_F00D;
    tick();
    rvalid = 1'b0;
    chk1("rm_r_rsp", rsp_valid, 1'b1);
    chk32("rm_r_rdata", rsp_rdata, 32'h0BAD_F00D);
    chk1("rm_r_err", rsp_err, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
